// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  // Decoder input that renders all segments off.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    StDead,
    StShow
  } scan_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Terminal-count tick generator; restarts from zero after every tick so each new
// state begins counting against its own terminal value.
module scan_prescaler #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] term,
  output logic             tick
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == term);
    cnt_d = tick ? '0 : cnt_q + Width'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scan for a shared BCD-to-7-segment decoder, with
// frame-aligned double buffering and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned PRESCALE         = 50000,
  parameter int unsigned DEAD_CYCLES      = 2,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    lz_blank_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    load_ack
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned CntMax = ((PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES) - 1;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

  localparam logic [CntW-1:0]       ShowTerm = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0]       DeadTerm = CntW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IdxW-1:0]       LastIdx  = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EnOff    = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam scan_state_e           StReset  = (DEAD_CYCLES > 0) ? StDead : StShow;

  scan_state_e                 state_q, state_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  bcd_t [NUM_DIGITS-1:0]       pend_q, pend_d;
  bcd_t [NUM_DIGITS-1:0]       act_q, act_d;
  logic                        pend_v_q, pend_v_d;
  logic                        tick;
  logic                        frame_start;
  logic [CntW-1:0]             term;
  logic                        zero_run;
  logic [NUM_DIGITS-1:0]       blank;
  logic [NUM_DIGITS-1:0]       digit_en_d;
  bcd_t                        bcd_out_d;
  logic                        load_ack_d;

  // The terminal value follows the current state, so a state change reloads the slot length.
  always_comb begin
    term = (state_q == StShow) ? ShowTerm : DeadTerm;
  end

  scan_prescaler #(
    .Width (CntW)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .term  (term),
    .tick  (tick)
  );

  // State register, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StReset;
      idx_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      act_q    <= '0;
      bcd_out  <= BLANK_CODE;
      digit_en <= EnOff;
      load_ack <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      act_q    <= act_d;
      bcd_out  <= bcd_out_d;
      digit_en <= digit_en_d;
      load_ack <= load_ack_d;
    end
  end

  // Next-state: SHOW advances the digit index; DEAD keeps it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (tick) begin
      if (state_q == StShow) begin
        idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
        state_d = (DEAD_CYCLES > 0) ? StDead : StShow;
      end else begin
        state_d = StShow;
      end
    end
  end

  // Pending data moves to the active buffer only as the idx-0 slot begins.
  always_comb begin
    frame_start = tick && (state_d == StShow) && (idx_d == '0);
    pend_d      = load ? bcd_t'(0) : bcd_t'(0);
    pend_d      = load ? bcd_in : pend_q;
    pend_v_d    = pend_v_q;
    if (load) begin
      pend_v_d = 1'b1;
    end else if (frame_start) begin
      pend_v_d = 1'b0;
    end
    act_d      = act_q;
    load_ack_d = 1'b0;
    if (frame_start && pend_v_q) begin
      act_d      = pend_q;
      load_ack_d = 1'b1;
    end
  end

  // Outputs are computed from next-state values so they move with the state registers.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (act_d[i] == 4'h0);
      blank[i] = lz_blank_en & zero_run & (i != 0);
    end
    digit_en_d = EnOff;
    bcd_out_d  = BLANK_CODE;
    if (state_d == StShow) begin
      digit_en_d = EnOff ^ (NUM_DIGITS'(1) << idx_d);
      bcd_out_d  = blank[idx_d] ? BLANK_CODE : act_d[idx_d];
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed display scan controller for the ticket counter's multi-digit 7-segment display. One combinational BCD-to-7-segment decoder is shared across all digits; this block is the only thing that drives the decoder input. It rotates the decoder input through the digits and drives the digit enables in step. It also double-buffers the displayed count so a digit never shows a mix of old and new values, and it applies optional leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
PRESCALE, 50000, clk cycles each digit is lit (SHOW slot length); must be >= 1.
DEAD_CYCLES, 2, clk cycles with all digits off between slots (anti-ghosting); 0 removes the DEAD state.
ANODE_ACTIVE_LOW, 1, 1 means an enabled digit drives 0 on digit_en; 0 means it drives 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
bcd_in  in  4*NUM_DIGITS  packed BCD digits; digit 0 (least significant) sits at [3:0]
load  in  1  one-cycle strobe that captures bcd_in into the pending buffer
lz_blank_en  in  1  1 enables leading-zero blanking
bcd_out  out  4  BCD value sent to the shared 7-segment decoder
digit_en  out  NUM_DIGITS  digit (anode) enables, one-hot or all-off, polarity set by ANODE_ACTIVE_LOW
load_ack  out  1  one-cycle pulse when pending data is transferred to the active buffer

Behaviour:
- Registers:
  - prescale counter cnt;
  - digit index idx (0..NUM_DIGITS-1);
  - state, either DEAD or SHOW;
  - pending buffer pend, with flag pend_v;
  - active buffer act.
- All outputs are registered and update on the same edge that moves the state registers; there is no combinational path from any input to any output.
- Reset (rst_n low, takes effect immediately and asynchronously):
  - state=DEAD, idx=0, cnt=0;
  - pend=0, pend_v=0, act=0;
  - bcd_out=4'hF (BLANK code, which the decoder maps to all segments off);
  - digit_en = all inactive (all 1s when ANODE_ACTIVE_LOW=1);
  - load_ack=0.
- DEAD state:
  - all digits inactive; bcd_out=4'hF;
  - stays DEAD_CYCLES cycles, then moves to SHOW with the same idx.
  - If DEAD_CYCLES=0, DEAD is never entered: SHOW follows SHOW directly, and the state out of reset is SHOW with idx=0.
- SHOW state:
  - digit_en enables only digit idx; bcd_out = displayed value of digit idx;
  - stays PRESCALE cycles, then idx increments (wrapping NUM_DIGITS-1 -> 0) and the state moves to DEAD.
- Scan timing:
  - slot period = PRESCALE + DEAD_CYCLES;
  - frame period = NUM_DIGITS x slot period.
- Load / double buffering:
  - load=1 sets pend <= bcd_in and pend_v <= 1, in any state.
  - Frame boundary = the cycle in which SHOW of idx 0 begins. At that cycle, if pend_v=1: act <= pend, pend_v <= 0, load_ack=1 for that single cycle.
  - load on the frame-boundary cycle: the transfer uses the previous pend; the new data stays pending until the next frame; pend_v remains 1.
  - Several loads within one frame: the last one wins, and only one load_ack is issued.
  - No load at all: act holds its value indefinitely.
- Displayed value of digit i:
  - BLANK (4'hF) when lz_blank_en=1, i>0, and act digits NUM_DIGITS-1 down to i are all zero;
  - otherwise act digit i.
  - Digit 0 is never blanked, so an all-zero count displays "0".
  - lz_blank_en is sampled live each cycle; it does not wait for a frame boundary.
- Non-BCD digits (A-F) in act are passed through unchanged; the decoder renders them blank.
- Counter widths:
  - cnt is wide enough for max(PRESCALE, DEAD_CYCLES)-1;
  - idx is clog2(NUM_DIGITS) bits;
  - no counter ever exceeds its terminal value.

Decomposition:
- Shared package seg_pkg holds:
  - BLANK_CODE = 4'hF;
  - the scan state enum (DEAD, SHOW);
  - the BCD digit typedef (4-bit).
- One sub-module is natural: scan_prescaler, a terminal-count tick generator with a load value, instantiated once and reloaded with PRESCALE or DEAD_CYCLES on each state change.

Test Plan:
Bench parameters: NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1.
1. Reset release -> digit_en=4'b1111 and bcd_out=F for 1 cycle, then digit_en=4'b1110 for 4 cycles, then 1 dead cycle, then 4'b1101; frame period = 20 cycles.
2. load with bcd_in=16'h1234 before the frame boundary -> load_ack pulses at the start of the idx-0 slot; bcd_out shows 4, 3, 2, 1 with digit_en 1110, 1101, 1011, 0111.
3. act=16'h0007, lz_blank_en=1 -> digits 1-3 show F and digit 0 shows 7.
   act=16'h0000 -> digit 0 shows 0, others F.
   lz_blank_en=0 -> all four digits show 0.
4. Anti-tearing: load 16'h5678 mid-frame while displaying 1234 -> remaining slots of that frame still show 1234; 5678 appears from the next frame.
   Loads of 16'h1111 then 16'h2222 within one frame -> a single load_ack, and 2222 is displayed.
5. rst_n asserted mid-SHOW with act=16'h9999 -> digit_en=4'b1111 and bcd_out=F immediately, without waiting for a clock edge.
   After release, the display shows 0000, or 0 plus three blanks when lz_blank_en=1.
6. bcd_in=16'h00A0 with lz_blank_en=0 -> digit 1 shows A and is passed through.
   load on the exact frame-boundary cycle -> no ack in that frame; ack arrives at the next boundary.
